// File: rtl/kyber_prehash_seq_if.sv
// Shared SHA3 core job bus: the sequencer is master, the hash core is slave.
interface kyber_prehash_seq_if #(
   parameter int EK_BITS = 12*3*256+256
);
   logic               hash_start;
   logic               hash_sel;
   logic [15:0]        hash_len;
   logic [EK_BITS-1:0] hash_msg;
   logic               hash_done;
   logic [511:0]       hash_digest;

   modport master (
      output hash_start, hash_sel, hash_len, hash_msg,
      input  hash_done, hash_digest
   );

   modport slave (
      input  hash_start, hash_sel, hash_len, hash_msg,
      output hash_done, hash_digest
   );
endinterface

// File: rtl/kyber_prehash_seq.sv
// Kyber pre-encryption hash chain sequencer: m = H(rand), hek = H(ek), (pre_k, coin) = G(m || hek)
// over one shared SHA3 core, with hek caching, decaps mode and a per-job watchdog.
//
// state    | meaning
// IDLE     | waiting for start
// HM_REQ   | H(rand) job pulse issued
// HM_WAIT  | waiting for H(rand) digest
// HEK_REQ  | H(ek) job pulse issued
// HEK_WAIT | waiting for H(ek) digest
// G_REQ    | G(m || hek) job pulse issued
// G_WAIT   | waiting for G digest
// DONE     | results published, valid high
module kyber_prehash_seq #(
   parameter int KYBER_K = 3,
   parameter int KYBER_N = 256,
   parameter int EK_BITS = 12*KYBER_K*KYBER_N+256,
   parameter int TIMEOUT = 4096
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                mode_decaps,
   input  logic                ek_reuse,
   input  logic [EK_BITS-1:0]  ek,
   input  logic [255:0]        rand_in,
   input  logic [255:0]        msg_in,
   kyber_prehash_seq_if.master core,
   output logic                busy,
   output logic                valid,
   output logic                error,
   output logic [255:0]        msg,
   output logic [255:0]        hek,
   output logic [255:0]        pre_k,
   output logic [255:0]        coin
);
   localparam logic [15:0] LEN_H  = 16'd32;
   localparam logic [15:0] LEN_EK = 16'(12*KYBER_K*KYBER_N/8 + 32);
   localparam logic [15:0] LEN_G  = 16'd64;
   localparam int          WD_W   = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT-1);

   typedef enum logic [2:0] {
      IDLE, HM_REQ, HM_WAIT, HEK_REQ, HEK_WAIT, G_REQ, G_WAIT, DONE
   } state_t;

   state_t             state;
   logic               reuse_r;
   logic               cache_valid;
   logic [255:0]       m_r;
   logic [255:0]       hek_cache;
   logic [EK_BITS-1:0] ek_r;
   logic [WD_W-1:0]    wd_cnt;

   function automatic logic [EK_BITS-1:0] pad256(input logic [255:0] d);
      return {{(EK_BITS-256){1'b0}}, d};
   endfunction

   function automatic logic [EK_BITS-1:0] pad512(input logic [511:0] d);
      return {{(EK_BITS-512){1'b0}}, d};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         busy             <= 1'b0;
         valid            <= 1'b0;
         error            <= 1'b0;
         msg              <= '0;
         hek              <= '0;
         pre_k            <= '0;
         coin             <= '0;
         core.hash_start  <= 1'b0;
         core.hash_sel    <= 1'b0;
         core.hash_len    <= '0;
         core.hash_msg    <= '0;
         reuse_r          <= 1'b0;
         cache_valid      <= 1'b0;
         m_r              <= '0;
         hek_cache        <= '0;
         ek_r             <= '0;
         wd_cnt           <= '0;
      end else begin
         core.hash_start <= 1'b0;
         valid           <= 1'b0;
         error           <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  busy            <= 1'b1;
                  reuse_r         <= ek_reuse;
                  ek_r            <= ek;
                  core.hash_start <= 1'b1;
                  if (!mode_decaps) begin
                     state         <= HM_REQ;
                     core.hash_sel <= 1'b0;
                     core.hash_len <= LEN_H;
                     core.hash_msg <= pad256(rand_in);
                  end else begin
                     m_r <= msg_in;
                     if (ek_reuse && cache_valid) begin
                        state         <= G_REQ;
                        core.hash_sel <= 1'b1;
                        core.hash_len <= LEN_G;
                        core.hash_msg <= pad512({hek_cache, msg_in});
                     end else begin
                        state         <= HEK_REQ;
                        core.hash_sel <= 1'b0;
                        core.hash_len <= LEN_EK;
                        core.hash_msg <= ek;
                     end
                  end
               end
            end
            HM_REQ: begin
               state  <= HM_WAIT;
               wd_cnt <= WD_LOAD;
            end
            HEK_REQ: begin
               state  <= HEK_WAIT;
               wd_cnt <= WD_LOAD;
            end
            G_REQ: begin
               state  <= G_WAIT;
               wd_cnt <= WD_LOAD;
            end
            HM_WAIT, HEK_WAIT, G_WAIT: begin
               // a done arriving on the expiry cycle still completes the job
               if (core.hash_done) begin
                  unique case (state)
                     HM_WAIT: begin
                        m_r             <= core.hash_digest[255:0];
                        core.hash_start <= 1'b1;
                        if (reuse_r && cache_valid) begin
                           state         <= G_REQ;
                           core.hash_sel <= 1'b1;
                           core.hash_len <= LEN_G;
                           core.hash_msg <= pad512({hek_cache, core.hash_digest[255:0]});
                        end else begin
                           state         <= HEK_REQ;
                           core.hash_sel <= 1'b0;
                           core.hash_len <= LEN_EK;
                           core.hash_msg <= ek_r;
                        end
                     end
                     HEK_WAIT: begin
                        hek_cache       <= core.hash_digest[255:0];
                        cache_valid     <= 1'b1;
                        core.hash_start <= 1'b1;
                        state           <= G_REQ;
                        core.hash_sel   <= 1'b1;
                        core.hash_len   <= LEN_G;
                        core.hash_msg   <= pad512({core.hash_digest[255:0], m_r});
                     end
                     default: begin
                        state <= DONE;
                        valid <= 1'b1;
                        msg   <= m_r;
                        hek   <= hek_cache;
                        pre_k <= core.hash_digest[255:0];
                        coin  <= core.hash_digest[511:256];
                     end
                  endcase
               end else if (wd_cnt == '0) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  error       <= 1'b1;
                  cache_valid <= 1'b0;
               end else begin
                  wd_cnt <= wd_cnt - 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_kyber_prehash_seq.sv
// Bench for kyber_prehash_seq: behavioural hash core with scoreboarded jobs and results.
module tb_kyber_prehash_seq;
   localparam int K  = 3;
   localparam int N  = 256;
   localparam int EK = 12*K*N+256;
   localparam int TO = 16;
   localparam logic [15:0] LEN_EK = 16'd1184;

   typedef struct {
      logic         md;
      logic         reuse;
      int           seed;
      logic [255:0] r;
      logic [255:0] mi;
      int           jobs;
      logic [15:0]  flen;
      logic         hold;
   } vec_t;

   typedef struct {
      logic          sel;
      logic [15:0]   len;
      logic [EK-1:0] data;
      logic          first;
   } job_t;

   typedef struct {
      logic [255:0] m;
      logic [255:0] h;
      logic [255:0] pk;
      logic [255:0] cn;
   } res_t;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode_decaps = 1'b0, ek_reuse = 1'b0;
   logic [EK-1:0] ek = '0;
   logic [255:0] rand_in = '0, msg_in = '0;
   logic busy, valid, error;
   logic [255:0] msg, hek, pre_k, coin;

   kyber_prehash_seq_if #(.EK_BITS(EK)) hif();

   kyber_prehash_seq #(.KYBER_K(K), .KYBER_N(N), .EK_BITS(EK), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .mode_decaps(mode_decaps), .ek_reuse(ek_reuse),
      .ek(ek), .rand_in(rand_in), .msg_in(msg_in), .core(hif),
      .busy(busy), .valid(valid), .error(error),
      .msg(msg), .hek(hek), .pre_k(pre_k), .coin(coin)
   );

   always #5 clk = ~clk;

   int checks = 0, errs = 0;
   job_t jobq[$];
   res_t resq[$];
   res_t last_res, r_mon;
   job_t j_mon;
   int negcnt = 0, last_done_neg = -100, pend = 0, nvalid = 0, nerr = 0;
   int njobs_run = 0, model_lat = 5;
   logic [15:0] first_len = '0;
   logic model_en = 1'b1, expect_err = 1'b0;
   logic [511:0] pend_dig;
   logic cap_sel;
   logic [15:0] cap_len;
   logic [EK-1:0] cap_msg;
   logic cv = 1'b0;
   logic [255:0] ch = '0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] fake_hash(input logic sel, input logic [15:0] len,
                                               input logic [EK-1:0] m);
      logic [511:0] acc;
      acc = {32{len ^ {15'b0, sel}}};
      for (int i = 0; i < EK/256; i++) begin
         acc = {acc[504:0], acc[511:505]} ^ {m[i*256 +: 256], ~m[i*256 +: 256] ^ 256'(i)};
         acc = acc + {acc[255:0], acc[511:256]};
      end
      if (!sel) acc[511:256] = '0;
      return acc;
   endfunction

   function automatic logic [EK-1:0] mk_ek(input int s);
      logic [EK-1:0] e;
      for (int i = 0; i < EK/32; i++)
         e[i*32 +: 32] = (32'(s) * 32'h9E3779B9) ^ (32'(i) * 32'h85EBCA6B) ^ 32'(s + i);
      return e;
   endfunction

   // hash core model and output monitor share one process to keep sampling order fixed
   always @(negedge clk) begin
      negcnt++;
      if (valid) begin
         nvalid++;
         chk("valid_latency", 512'(negcnt - last_done_neg), 512'(1));
         if (resq.size() == 0) chk("unexpected_valid", 512'(1), 512'(0));
         else begin
            r_mon = resq.pop_front();
            chk("out_msg", 512'(msg), 512'(r_mon.m));
            chk("out_hek", 512'(hek), 512'(r_mon.h));
            chk("out_pre_k", 512'(pre_k), 512'(r_mon.pk));
            chk("out_coin", 512'(coin), 512'(r_mon.cn));
            last_res = r_mon;
         end
      end
      if (error) begin
         nerr++;
         if (!expect_err) chk("unexpected_error", 512'(1), 512'(0));
      end
      hif.hash_done = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            if (busy)
               chk("req_stable", 512'(hif.hash_sel == cap_sel && hif.hash_len == cap_len &&
                                      hif.hash_msg == cap_msg), 512'(1));
            hif.hash_done   = 1'b1;
            hif.hash_digest = pend_dig;
            last_done_neg   = negcnt;
         end
      end
      if (hif.hash_start) begin
         if (njobs_run == 0) first_len = hif.hash_len;
         njobs_run++;
         if (jobq.size() == 0) chk("unexpected_job", 512'(1), 512'(0));
         else begin
            j_mon = jobq.pop_front();
            chk("job_sel", 512'(hif.hash_sel), 512'(j_mon.sel));
            chk("job_len", 512'(hif.hash_len), 512'(j_mon.len));
            chk("job_msg", 512'(hif.hash_msg == j_mon.data), 512'(1));
            if (!j_mon.first) chk("start_gap", 512'(negcnt - last_done_neg), 512'(1));
         end
         cap_sel  = hif.hash_sel;
         cap_len  = hif.hash_len;
         cap_msg  = hif.hash_msg;
         pend_dig = fake_hash(hif.hash_sel, hif.hash_len, hif.hash_msg);
         if (model_en) pend = model_lat;
      end
   end

   task automatic run(input vec_t v);
      logic [EK-1:0] e;
      logic [255:0] m, h;
      logic [511:0] g;
      logic first;
      int nv0;
      e = mk_ek(v.seed);
      first = 1'b1;
      if (v.md) m = v.mi;
      else begin
         g = fake_hash(1'b0, 16'd32, EK'(v.r));
         m = g[255:0];
         jobq.push_back('{1'b0, 16'd32, EK'(v.r), first});
         first = 1'b0;
      end
      if (v.reuse && cv) h = ch;
      else begin
         g = fake_hash(1'b0, LEN_EK, e);
         h = g[255:0];
         jobq.push_back('{1'b0, LEN_EK, e, first});
         first = 1'b0;
         cv = 1'b1;
         ch = h;
      end
      jobq.push_back('{1'b1, 16'd64, EK'({h, m}), first});
      g = fake_hash(1'b1, 16'd64, EK'({h, m}));
      resq.push_back('{m, h, g[255:0], g[511:256]});
      nv0 = nvalid;
      njobs_run = 0;
      @(negedge clk);
      mode_decaps = v.md; ek_reuse = v.reuse; ek = e; rand_in = v.r; msg_in = v.mi;
      start = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (valid) break;
         if (v.hold) begin
            rand_in = {8{$urandom}};
            msg_in = {8{$urandom}};
            ek = mk_ek(int'($urandom));
            mode_decaps = 1'($urandom);
            ek_reuse = 1'($urandom);
         end else start = 1'b0;
      end
      start = 1'b0;
      @(negedge clk);
      chk("valid_count", 512'(nvalid - nv0), 512'(1));
      chk("jobs_left", 512'(jobq.size()), 512'(0));
      chk("job_count", 512'(njobs_run), 512'(v.jobs));
      chk("first_len", 512'(first_len), 512'(v.flen));
      resq.delete();
   endtask

   vec_t vecs[9];
   logic [EK-1:0] e_t;
   int nv0, ne0, s_neg, lat;

   initial begin
      vecs[0] = '{1'b0, 1'b0, 1, {8{32'h1234_5678}}, 256'd0, 3, 16'd32, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 1, 256'd0, {32{8'hA5}}, 2, LEN_EK, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 1, 256'd0, {8{32'hDEAD_BEEF}}, 1, 16'd64, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 2, {8{32'h0BAD_F00D}}, 256'd0, 2, 16'd32, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 2, {8{32'hCAFE_0001}}, 256'd0, 3, 16'd32, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 3, {8{32'h5555_AAAA}}, 256'd0, 3, 16'd32, 1'b1};
      vecs[6] = '{1'b1, 1'b1, 3, 256'd0, {8{32'h0F0F_1234}}, 1, 16'd64, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 4, 256'd0, {8{32'h7777_0000}}, 2, LEN_EK, 1'b0};
      vecs[8] = '{1'b0, 1'b1, 5, {8{32'h1357_9BDF}}, 256'd0, 3, 16'd32, 1'b0};
      last_res = '{256'd0, 256'd0, 256'd0, 256'd0};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 512'(busy), 512'(0));
      chk("rst_valid", 512'(valid), 512'(0));
      chk("rst_error", 512'(error), 512'(0));
      chk("rst_msg", 512'(msg), 512'(0));
      chk("rst_hek", 512'(hek), 512'(0));
      chk("rst_pre_k", 512'(pre_k), 512'(0));
      chk("rst_coin", 512'(coin), 512'(0));
      chk("rst_hash_start", 512'(hif.hash_start), 512'(0));
      chk("rst_hash_len", 512'(hif.hash_len), 512'(0));

      for (int i = 0; i < 6; i++) run(vecs[i]);

      model_lat = TO;
      run(vecs[6]);
      model_lat = 5;

      // watchdog expiry: H(ek) job never completes
      e_t = mk_ek(4);
      jobq.push_back('{1'b0, LEN_EK, e_t, 1'b1});
      model_en = 1'b0; expect_err = 1'b1;
      nv0 = nvalid; ne0 = nerr; s_neg = -1000; lat = -1;
      @(negedge clk);
      mode_decaps = 1'b1; ek_reuse = 1'b0; ek = e_t; start = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (hif.hash_start) s_neg = i;
         if (error) begin
            lat = i - s_neg;
            chk("busy_at_error", 512'(busy), 512'(0));
            break;
         end
      end
      chk("error_latency", 512'(lat), 512'(TO+1));
      @(negedge clk);
      chk("err_msg_kept", 512'(msg), 512'(last_res.m));
      chk("err_hek_kept", 512'(hek), 512'(last_res.h));
      chk("err_pre_k_kept", 512'(pre_k), 512'(last_res.pk));
      chk("err_coin_kept", 512'(coin), 512'(last_res.cn));
      chk("err_no_valid", 512'(nvalid - nv0), 512'(0));
      chk("err_pulses", 512'(nerr - ne0), 512'(1));
      model_en = 1'b1; expect_err = 1'b0; cv = 1'b0;
      run(vecs[7]);

      // reset during HEK_WAIT with the core's done still in flight
      e_t = mk_ek(5);
      jobq.push_back('{1'b0, LEN_EK, e_t, 1'b1});
      nv0 = nvalid;
      @(negedge clk);
      mode_decaps = 1'b1; ek_reuse = 1'b0; ek = e_t; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("arst_no_valid", 512'(nvalid - nv0), 512'(0));
      chk("arst_busy", 512'(busy), 512'(0));
      chk("arst_msg", 512'(msg), 512'(0));
      chk("arst_hek", 512'(hek), 512'(0));
      chk("arst_pre_k", 512'(pre_k), 512'(0));
      chk("arst_coin", 512'(coin), 512'(0));
      chk("arst_hash_start", 512'(hif.hash_start), 512'(0));
      chk("arst_jobs", 512'(jobq.size()), 512'(0));
      cv = 1'b0;
      run(vecs[8]);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end
endmodule
